// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result classes and widths for the execute stage.
// Imported by the EX interface, the divider and the stage top.
package ex_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int ALUOP_W   = 8;
  localparam int ALUSEL_W  = 3;
  localparam int DIV_ITERS = DATA_W;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [DATA_W-1:0] ZeroWord = '0;

  localparam logic [ALUOP_W-1:0] ALU_OP_NOP   = 8'h00;
  localparam logic [ALUOP_W-1:0] ALU_OP_AND   = 8'h24;
  localparam logic [ALUOP_W-1:0] ALU_OP_OR    = 8'h25;
  localparam logic [ALUOP_W-1:0] ALU_OP_XOR   = 8'h26;
  localparam logic [ALUOP_W-1:0] ALU_OP_NOR   = 8'h27;
  localparam logic [ALUOP_W-1:0] ALU_OP_LUI   = 8'h5C;
  localparam logic [ALUOP_W-1:0] ALU_OP_SLL   = 8'h7C;
  localparam logic [ALUOP_W-1:0] ALU_OP_SRL   = 8'h02;
  localparam logic [ALUOP_W-1:0] ALU_OP_SRA   = 8'h03;
  localparam logic [ALUOP_W-1:0] ALU_OP_SLT   = 8'h2A;
  localparam logic [ALUOP_W-1:0] ALU_OP_SLTU  = 8'h2B;
  localparam logic [ALUOP_W-1:0] ALU_OP_ADDU  = 8'h21;
  localparam logic [ALUOP_W-1:0] ALU_OP_SUBU  = 8'h23;
  localparam logic [ALUOP_W-1:0] ALU_OP_MULT  = 8'h18;
  localparam logic [ALUOP_W-1:0] ALU_OP_MULTU = 8'h19;
  localparam logic [ALUOP_W-1:0] ALU_OP_DIV   = 8'h1A;
  localparam logic [ALUOP_W-1:0] ALU_OP_DIVU  = 8'h1B;
  localparam logic [ALUOP_W-1:0] ALU_OP_MFHI  = 8'h10;
  localparam logic [ALUOP_W-1:0] ALU_OP_MTHI  = 8'h11;
  localparam logic [ALUOP_W-1:0] ALU_OP_MFLO  = 8'h12;
  localparam logic [ALUOP_W-1:0] ALU_OP_MTLO  = 8'h13;
  localparam logic [ALUOP_W-1:0] ALU_OP_JAL   = 8'h50;
  localparam logic [ALUOP_W-1:0] ALU_OP_LW    = 8'hE3;
  localparam logic [ALUOP_W-1:0] ALU_OP_SW    = 8'hEB;

  localparam logic [ALUSEL_W-1:0] ALU_RES_NOP   = 3'd0;
  localparam logic [ALUSEL_W-1:0] ALU_RES_LOGIC = 3'd1;
  localparam logic [ALUSEL_W-1:0] ALU_RES_SHIFT = 3'd2;
  localparam logic [ALUSEL_W-1:0] ALU_RES_MOVE  = 3'd3;
  localparam logic [ALUSEL_W-1:0] ALU_RES_ARITH = 3'd4;
  localparam logic [ALUSEL_W-1:0] ALU_RES_JUMP  = 3'd6;
  localparam logic [ALUSEL_W-1:0] ALU_RES_MEM   = 3'd7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM, writeback and HI/LO outputs of the
// execute stage; master drives the instruction, slave is the stage.
interface ex_stage_if
  import ex_stage_pkg::*;
();

  logic                flush;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_reg1;
  logic [DATA_W-1:0]   ex_reg2;
  logic [4:0]          ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_return_addr;
  logic [DATA_W-1:0]   ex_inst;
  logic [DATA_W-1:0]   ex_pc;

  logic [4:0]          wb_wd;
  logic                wb_wreg;
  logic [DATA_W-1:0]   wb_wdata;
  logic [ALUOP_W-1:0]  mem_aluop;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [DATA_W-1:0]   mem_pc;
  logic                stallreq;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;

  modport master (
    output flush, ex_aluop, ex_alusel,
    output ex_reg1, ex_reg2, ex_wd, ex_wreg,
    output ex_return_addr, ex_inst, ex_pc,
    input  wb_wd, wb_wreg, wb_wdata,
    input  mem_aluop, mem_addr, mem_reg2, mem_pc,
    input  stallreq, hi_o, lo_o
  );

  modport slave (
    input  flush, ex_aluop, ex_alusel,
    input  ex_reg1, ex_reg2, ex_wd, ex_wreg,
    input  ex_return_addr, ex_inst, ex_pc,
    output wb_wd, wb_wreg, wb_wdata,
    output mem_aluop, mem_addr, mem_reg2, mem_pc,
    output stallreq, hi_o, lo_o
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Restoring shift-subtract divider, one quotient bit per cycle,
// with magnitude latch on start and sign fixup on the outputs.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        state, nstate;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] r, q, d;
  logic              neg_q, neg_r;
  logic              zero_div;
  logic [DATA_W-1:0] dvd_abs, dvs_abs;
  logic [DATA_W:0]   r_sh, diff;

  assign zero_div = (divisor == ZeroWord);
  assign dvd_abs  = (signed_op && dividend[DATA_W-1])
                  ? -dividend : dividend;
  assign dvs_abs  = (signed_op && divisor[DATA_W-1])
                  ? -divisor : divisor;

  assign r_sh = {r, q[DATA_W-1]};
  assign diff = r_sh - {1'b0, d};

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    case (state)
      DIV_IDLE: if (start) begin
        busy   = 1'b1;
        nstate = zero_div ? DIV_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (cnt == CNT_W'(DIV_ITERS - 1))
          nstate = DIV_DONE;
      end
      DIV_DONE: nstate = DIV_IDLE;
      default:  nstate = DIV_IDLE;
    endcase
    if (abort) begin
      nstate = DIV_IDLE;
      busy   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= nstate;
      if (state == DIV_IDLE && start && !abort) begin
        cnt   <= '0;
        d     <= dvs_abs;
        neg_r <= signed_op & dividend[DATA_W-1];
        // x/0 yields all-ones quotient and the dividend as remainder
        if (zero_div) begin
          q     <= '1;
          r     <= dvd_abs;
          neg_q <= 1'b0;
        end else begin
          q     <= dvd_abs;
          r     <= '0;
          neg_q <= signed_op &
                   (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
        end
      end else if (state == DIV_BUSY && !abort) begin
        cnt <= cnt + 1'b1;
        if (!diff[DATA_W]) begin
          r <= diff[DATA_W-1:0];
          q <= {q[DATA_W-2:0], 1'b1};
        end else begin
          r <= r_sh[DATA_W-1:0];
          q <= {q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -q : q;
  assign remainder = neg_r ? -r : r;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU/shift/compare results, HI/LO registers,
// single-cycle multiply and a stalling sequential divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  ex_stage_if.slave bus
);

  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   a, b;
  logic [DATA_W-1:0]   alu_res;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                is_div, no_wb;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   quo, rem;
  logic                unused_inst;

  assign a = bus.ex_reg1;
  assign b = bus.ex_reg2;

  assign is_div = (bus.ex_aluop == ALU_OP_DIV) ||
                  (bus.ex_aluop == ALU_OP_DIVU);

  div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (bus.ex_aluop == ALU_OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .abort     (bus.flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // low 64 bits of the sign-extended product are the signed product
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} *
                  {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {ZeroWord, a} * {ZeroWord, b};

  always_comb begin
    alu_res = ZeroWord;
    case (bus.ex_aluop)
      ALU_OP_AND:  alu_res = a & b;
      ALU_OP_OR:   alu_res = a | b;
      ALU_OP_XOR:  alu_res = a ^ b;
      ALU_OP_NOR:  alu_res = ~(a | b);
      ALU_OP_LUI:  alu_res = b;
      ALU_OP_SLL:  alu_res = b << a[4:0];
      ALU_OP_SRL:  alu_res = b >> a[4:0];
      ALU_OP_SRA:  alu_res = DATA_W'($signed(b) >>> a[4:0]);
      ALU_OP_SLT:  alu_res = DATA_W'($signed(a) < $signed(b));
      ALU_OP_SLTU: alu_res = DATA_W'(a < b);
      ALU_OP_ADDU: alu_res = a + b;
      ALU_OP_SUBU: alu_res = a - b;
      ALU_OP_MFHI: alu_res = hi;
      ALU_OP_MFLO: alu_res = lo;
      default:     alu_res = ZeroWord;
    endcase
  end

  always_comb begin
    bus.wb_wdata = ZeroWord;
    case (bus.ex_alusel)
      ALU_RES_LOGIC,
      ALU_RES_SHIFT,
      ALU_RES_ARITH,
      ALU_RES_MOVE: bus.wb_wdata = alu_res;
      ALU_RES_JUMP: bus.wb_wdata = bus.ex_return_addr;
      default:      bus.wb_wdata = ZeroWord;
    endcase
  end

  assign no_wb = is_div ||
                 (bus.ex_aluop == ALU_OP_MULT)  ||
                 (bus.ex_aluop == ALU_OP_MULTU) ||
                 (bus.ex_aluop == ALU_OP_MTHI)  ||
                 (bus.ex_aluop == ALU_OP_MTLO);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (!bus.flush) begin
      if (div_done) begin
        hi <= rem;
        lo <= quo;
      end else begin
        case (bus.ex_aluop)
          ALU_OP_MULT:  {hi, lo} <= prod_s;
          ALU_OP_MULTU: {hi, lo} <= prod_u;
          ALU_OP_MTHI:  hi <= a;
          ALU_OP_MTLO:  lo <= a;
          default: ;
        endcase
      end
    end
  end

  assign bus.stallreq  = div_busy;
  assign bus.wb_wd     = bus.ex_wd;
  assign bus.wb_wreg   = bus.ex_wreg & ~no_wb & ~div_busy;
  assign bus.mem_aluop = bus.ex_aluop;
  assign bus.mem_addr  = a + {{16{bus.ex_inst[15]}},
                              bus.ex_inst[15:0]};
  assign bus.mem_reg2  = b;
  assign bus.mem_pc    = bus.ex_pc;
  assign bus.hi_o      = hi;
  assign bus.lo_o      = lo;
  assign unused_inst   = ^bus.ex_inst[DATA_W-1:16];

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops,
// hand sequences for multiply, divide, flush and reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_if bus();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] inst;
    logic [31:0] ret;
    logic        wreg;
    logic [31:0] e_wdata;
    logic        e_wreg;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op,
                       input logic [2:0] sel,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic wreg);
    bus.ex_aluop       = op;
    bus.ex_alusel      = sel;
    bus.ex_reg1        = r1;
    bus.ex_reg2        = r2;
    bus.ex_wreg        = wreg;
    bus.ex_wd          = 5'd9;
    bus.ex_inst        = 32'h0;
    bus.ex_return_addr = 32'h0;
    bus.ex_pc          = 32'h0040_0000;
  endtask

  task automatic nop();
    drive(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
  endtask

  // runs a divide from a negedge; returns the number of stall cycles
  task automatic run_div(input logic [7:0] op,
                         input logic [31:0] dvd,
                         input logic [31:0] dvs,
                         output int n);
    drive(op, ALU_RES_NOP, dvd, dvs, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stallreq) break;
      if (n == 0) check("div_wreg_stall", 32'(bus.wb_wreg), 32'h0);
      n++;
      @(negedge clk);
    end
    nop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.flush = 1'b0;
    nop();

    vt[0]  = '{ALU_OP_ADDU, ALU_RES_ARITH, 32'h7FFFFFFF, 32'h1,
               32'h0, 32'h0, 1'b1, 32'h80000000, 1'b1, 32'h7FFFFFFF};
    vt[1]  = '{ALU_OP_SUBU, ALU_RES_ARITH, 32'h0, 32'h1,
               32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0};
    vt[2]  = '{ALU_OP_SLT, ALU_RES_ARITH, 32'hFFFFFFFF, 32'h1,
               32'h0, 32'h0, 1'b1, 32'h1, 1'b1, 32'hFFFFFFFF};
    vt[3]  = '{ALU_OP_SLTU, ALU_RES_ARITH, 32'hFFFFFFFF, 32'h1,
               32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFF};
    vt[4]  = '{ALU_OP_AND, ALU_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00,
               32'h0, 32'h0, 1'b1, 32'hF000F000, 1'b1, 32'hF0F0F0F0};
    vt[5]  = '{ALU_OP_OR, ALU_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00,
               32'h0, 32'h0, 1'b1, 32'hFFF0FFF0, 1'b1, 32'hF0F0F0F0};
    vt[6]  = '{ALU_OP_XOR, ALU_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00,
               32'h0, 32'h0, 1'b1, 32'h0FF00FF0, 1'b1, 32'hF0F0F0F0};
    vt[7]  = '{ALU_OP_NOR, ALU_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00,
               32'h0, 32'h0, 1'b1, 32'h000F000F, 1'b1, 32'hF0F0F0F0};
    vt[8]  = '{ALU_OP_LUI, ALU_RES_LOGIC, 32'h0, 32'h12340000,
               32'h0, 32'h0, 1'b1, 32'h12340000, 1'b1, 32'h0};
    vt[9]  = '{ALU_OP_SLL, ALU_RES_SHIFT, 32'h4, 32'h0000000F,
               32'h0, 32'h0, 1'b1, 32'h000000F0, 1'b1, 32'h4};
    vt[10] = '{ALU_OP_SRL, ALU_RES_SHIFT, 32'h24, 32'h80000000,
               32'h0, 32'h0, 1'b1, 32'h08000000, 1'b1, 32'h24};
    vt[11] = '{ALU_OP_SRA, ALU_RES_SHIFT, 32'h4, 32'h80000000,
               32'h0, 32'h0, 1'b1, 32'hF8000000, 1'b1, 32'h4};
    vt[12] = '{ALU_OP_JAL, ALU_RES_JUMP, 32'h0, 32'h0,
               32'h0, 32'h00400008, 1'b1, 32'h00400008, 1'b1, 32'h0};
    vt[13] = '{8'hFF, ALU_RES_ARITH, 32'h5, 32'h6,
               32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h5};
    vt[14] = '{ALU_OP_LW, ALU_RES_MEM, 32'h1000, 32'h0,
               32'h8C02FFFC, 32'h0, 1'b1, 32'h0, 1'b1, 32'h00000FFC};
    vt[15] = '{ALU_OP_MFHI, ALU_RES_MOVE, 32'h0, 32'h0,
               32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hi", bus.hi_o, 32'h0);
    check("rst_lo", bus.lo_o, 32'h0);
    check("rst_stall", 32'(bus.stallreq), 32'h0);
    check("bubble_wreg", 32'(bus.wb_wreg), 32'h0);
    check("bubble_wdata", bus.wb_wdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].sel, vt[i].r1, vt[i].r2, vt[i].wreg);
      bus.ex_inst        = vt[i].inst;
      bus.ex_return_addr = vt[i].ret;
      #1;
      check($sformatf("vec%0d_wdata", i), bus.wb_wdata, vt[i].e_wdata);
      check($sformatf("vec%0d_wreg", i), 32'(bus.wb_wreg),
            32'(vt[i].e_wreg));
      check($sformatf("vec%0d_addr", i), bus.mem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_stall", i), 32'(bus.stallreq), 32'h0);
    end

    @(negedge clk);
    drive(ALU_OP_SW, ALU_RES_MEM, 32'h2000, 32'hCAFEF00D, 1'b0);
    bus.ex_inst = 32'hAC030010;
    bus.ex_pc   = 32'h00400100;
    #1;
    check("pass_reg2", bus.mem_reg2, 32'hCAFEF00D);
    check("pass_pc", bus.mem_pc, 32'h00400100);
    check("pass_aluop", 32'(bus.mem_aluop), 32'(ALU_OP_SW));
    check("pass_wd", 32'(bus.wb_wd), 32'd9);
    check("sw_addr", bus.mem_addr, 32'h00002010);

    @(negedge clk);
    drive(ALU_OP_MULT, ALU_RES_NOP, 32'hFFFFFFFE, 32'h3, 1'b1);
    #1;
    check("mult_wreg", 32'(bus.wb_wreg), 32'h0);
    @(posedge clk);
    #1;
    check("mult_hi", bus.hi_o, 32'hFFFFFFFF);
    check("mult_lo", bus.lo_o, 32'hFFFFFFFA);
    @(negedge clk);
    drive(ALU_OP_MFLO, ALU_RES_MOVE, 32'h0, 32'h0, 1'b1);
    #1;
    check("mflo", bus.wb_wdata, 32'hFFFFFFFA);
    @(negedge clk);
    drive(ALU_OP_MULTU, ALU_RES_NOP, 32'hFFFFFFFE, 32'h3, 1'b1);
    @(posedge clk);
    #1;
    check("multu_hi", bus.hi_o, 32'h00000002);
    check("multu_lo", bus.lo_o, 32'hFFFFFFFA);
    @(negedge clk);
    drive(ALU_OP_MTHI, ALU_RES_NOP, 32'hA5A5A5A5, 32'h0, 1'b1);
    #1;
    check("mthi_wreg", 32'(bus.wb_wreg), 32'h0);
    @(negedge clk);
    drive(ALU_OP_MTLO, ALU_RES_NOP, 32'h5A5A5A5A, 32'h0, 1'b1);
    @(negedge clk);
    drive(ALU_OP_MFHI, ALU_RES_MOVE, 32'h0, 32'h0, 1'b1);
    #1;
    check("mfhi", bus.wb_wdata, 32'hA5A5A5A5);
    check("mtlo_lo", bus.lo_o, 32'h5A5A5A5A);

    @(negedge clk);
    run_div(ALU_OP_DIV, 32'hFFFFFFF9, 32'h2, n);
    check("div_stall_cycles", 32'(n), 32'd33);
    check("div_lo", bus.lo_o, 32'hFFFFFFFD);
    check("div_hi", bus.hi_o, 32'hFFFFFFFF);

    @(negedge clk);
    run_div(ALU_OP_DIVU, 32'd100, 32'd7, n);
    check("divu_stall_cycles", 32'(n), 32'd33);
    check("divu_lo", bus.lo_o, 32'd14);
    check("divu_hi", bus.hi_o, 32'd2);

    @(negedge clk);
    run_div(ALU_OP_DIVU, 32'h1234, 32'h0, n);
    check("div0_stall_cycles", 32'(n), 32'd1);
    check("div0_lo", bus.lo_o, 32'hFFFFFFFF);
    check("div0_hi", bus.hi_o, 32'h00001234);

    @(negedge clk);
    drive(ALU_OP_DIV, ALU_RES_NOP, 32'd1000, 32'd3, 1'b1);
    #1;
    check("fl_start_stall", 32'(bus.stallreq), 32'h1);
    repeat (11) @(negedge clk);
    #1;
    check("fl_busy_stall", 32'(bus.stallreq), 32'h1);
    bus.flush = 1'b1;
    #1;
    check("fl_stall_now", 32'(bus.stallreq), 32'h0);
    @(negedge clk);
    bus.flush = 1'b0;
    nop();
    #1;
    check("fl_stall_after", 32'(bus.stallreq), 32'h0);
    check("fl_hi_kept", bus.hi_o, 32'h00001234);
    check("fl_lo_kept", bus.lo_o, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    #1;
    check("fl_idle", 32'(bus.stallreq), 32'h0);

    @(negedge clk);
    drive(ALU_OP_DIVU, ALU_RES_NOP, 32'd50, 32'd7, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nop();
    #1;
    check("rst_mid_hi", bus.hi_o, 32'h0);
    check("rst_mid_lo", bus.lo_o, 32'h0);
    check("rst_mid_stall", 32'(bus.stallreq), 32'h0);

    @(negedge clk);
    run_div(ALU_OP_DIVU, 32'd9, 32'd3, n);
    check("div93_stall_cycles", 32'(n), 32'd33);
    check("div93_lo", bus.lo_o, 32'd3);
    check("div93_hi", bus.hi_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
